// File: rtl/pattern_det_param.sv
// Serial pattern detector: matches the last PAT_LEN accepted bits against a
// loadable pattern/mask, pulses `out` one cycle later and keeps a saturating count.
module pattern_det_param #(
  parameter int                 PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PAT_RST = 5'b00101,
  parameter int                 CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic               in,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic [PAT_LEN-1:0] mask_in,
  input  logic               count_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_count
);
  localparam int            FW   = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

  logic [PAT_LEN-1:0] hist, pat, mask, nh;
  logic [FW-1:0]      fill, nf;
  logic               hit;
  logic               cnt_sat;

  always_comb begin
    nh      = {hist[PAT_LEN-2:0], in};
    nf      = (fill == FULL) ? FULL : fill + FW'(1);
    // A match needs a full window; masked-off positions never disagree.
    hit     = valid & ~pat_load & (nf == FULL) & ~|((nh ^ pat) & mask);
    cnt_sat = &match_count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist        <= '0;
      fill        <= '0;
      pat         <= PAT_RST;
      mask        <= '1;
      out         <= 1'b0;
      match_count <= '0;
    end else begin
      out <= hit;
      if (pat_load) begin
        // New pattern restarts the window; a same-cycle valid bit is dropped.
        pat  <= pat_in;
        mask <= mask_in;
        fill <= '0;
      end else if (valid) begin
        hist <= nh;
        fill <= (hit && !overlap) ? '0 : nf;
      end
      if (count_clr)
        match_count <= '0;
      else if (hit && !cnt_sat)
        match_count <= match_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pattern_det_param.sv
// Bench for pattern_det_param: queue-based window model checked every cycle,
// plus directed streams with literal expectations. Two DUTs (CNT_W 16 and 2).
module tb_pattern_det_param;
  localparam int P = 5;

  logic         clk = 1'b0;
  logic         rst, valid, din, overlap, pat_load, count_clr;
  logic [P-1:0] pat_in, mask_in;
  logic         out_a, out_b;
  logic [15:0]  cnt_a;
  logic [1:0]   cnt_b;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  pattern_det_param #(.PAT_LEN(P), .PAT_RST(5'b00101), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .valid(valid), .in(din), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .mask_in(mask_in),
    .count_clr(count_clr), .out(out_a), .match_count(cnt_a));

  pattern_det_param #(.PAT_LEN(P), .PAT_RST(5'b00101), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .valid(valid), .in(din), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .mask_in(mask_in),
    .count_clr(count_clr), .out(out_b), .match_count(cnt_b));

  // Model: window is the list of bits accepted since the last clear.
  int       q[$];
  logic [P-1:0] mpat, mmask;
  logic     exp_out = 1'b0;
  int       exp_ca = 0, exp_cb = 0;
  logic     armed = 1'b0;
  bit       mhit;

  always @(posedge clk) begin
    mhit = 1'b0;
    if (rst) begin
      q.delete();
      mpat   = 5'b00101;
      mmask  = '1;
      exp_out <= 1'b0;
      exp_ca  <= 0;
      exp_cb  <= 0;
      armed   <= 1'b1;
    end else begin
      if (pat_load) begin
        mpat  = pat_in;
        mmask = mask_in;
        q.delete();
      end else if (valid) begin
        q.push_back(int'(din));
        if (q.size() > P) void'(q.pop_front());
        if (q.size() == P) begin
          mhit = 1'b1;
          for (int i = 0; i < P; i++)
            if (mmask[P-1-i] && (q[i] != int'(mpat[P-1-i]))) mhit = 1'b0;
        end
        if (mhit && !overlap) q.delete();
      end
      exp_out <= mhit;
      exp_ca  <= count_clr ? 0 : ((mhit && exp_ca < 65535) ? exp_ca + 1 : exp_ca);
      exp_cb  <= count_clr ? 0 : ((mhit && exp_cb < 3) ? exp_cb + 1 : exp_cb);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      vectors++;
      if (out_a !== exp_out || out_b !== exp_out) begin
        errors++;
        $display("FAIL model_out t=%0t got a=%b b=%b want %b", $time, out_a, out_b, exp_out);
      end
      vectors++;
      if (cnt_a !== 16'(exp_ca) || cnt_b !== 2'(exp_cb)) begin
        errors++;
        $display("FAIL model_cnt t=%0t got a=%0d b=%0d want a=%0d b=%0d",
                 $time, cnt_a, cnt_b, exp_ca, exp_cb);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic b,
                       input logic pl, input logic cc);
    rst = r; valid = v; din = b; pat_load = pl; count_clr = cc;
    @(posedge clk);
    #1;
    rst = 1'b0; valid = 1'b0; pat_load = 1'b0; count_clr = 1'b0;
  endtask

  task automatic bit_in(input logic b);
    drive(1'b0, 1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [P-1:0] p, input logic [P-1:0] m);
    pat_in = p; mask_in = m;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  // bits[n-1] goes first; pulses[k] is the expected out after the same bit.
  task automatic run_seq(input string name, input logic [15:0] bits,
                         input logic [15:0] pulses, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bit_in(bits[i]);
      chk($sformatf("%s_bit%0d_out", name, n - i), int'(out_a), int'(pulses[i]));
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; din = 1'b0; overlap = 1'b1;
    pat_load = 1'b0; count_clr = 1'b0; pat_in = '0; mask_in = '0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("reset_out", int'(out_a), 0);
    chk("reset_cnt", int'(cnt_a), 0);

    // Default pattern, one pulse after the fifth bit
    run_seq("dflt", 16'b00101, 16'b00001, 5);
    chk("dflt_cnt", int'(cnt_a), 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("idle_out", int'(out_a), 0);
    chk("clr_cnt", int'(cnt_a), 0);

    // 10101 overlapping vs non-overlapping
    load(5'b10101, 5'b11111);
    chk("load_out", int'(out_a), 0);
    run_seq("ovl", 16'b1010101, 16'b0000101, 7);
    chk("ovl_cnt", int'(cnt_a), 2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    overlap = 1'b0;
    load(5'b10101, 5'b11111);
    run_seq("novl", 16'b1010101, 16'b0000100, 7);
    chk("novl_cnt", int'(cnt_a), 1);
    overlap = 1'b1;

    // Valid gap does not break a partial pattern
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_seq("gap_pre", 16'b001, 16'b000, 3);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("gap_idle%0d_out", i), int'(out_a), 0);
    end
    run_seq("gap_post", 16'b01, 16'b01, 2);
    chk("gap_cnt", int'(cnt_a), 1);

    // Don't-care mask on bit 2
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    load(5'b00101, 5'b11011);
    run_seq("mask1", 16'b00101, 16'b00001, 5);
    load(5'b00101, 5'b11011);
    run_seq("mask2", 16'b00001, 16'b00001, 5);
    chk("mask_cnt", int'(cnt_a), 2);

    // Saturation on the 2-bit counter, then clear racing a match
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    load(5'b11111, 5'b11111);
    for (int i = 1; i <= 4; i++) bit_in(1'b1);
    for (int i = 0; i < 5; i++) begin
      bit_in(1'b1);
      chk($sformatf("sat%0d_cnt_b", i), int'(cnt_b), (i < 3) ? i + 1 : 3);
      chk($sformatf("sat%0d_cnt_a", i), int'(cnt_a), i + 1);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("clr_match_out", int'(out_a), 1);
    chk("clr_match_cnt_b", int'(cnt_b), 0);
    chk("clr_match_cnt_a", int'(cnt_a), 0);

    // All-zero mask: every bit once the window is full
    load(5'b10110, 5'b00000);
    run_seq("mask0", 16'b0110100, 16'b0000111, 7);

    // Reset mid-pattern, and reset clearing a live pulse
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_seq("rst_pre", 16'b0010, 16'b0000, 4);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    bit_in(1'b1);
    chk("rst_mid_out", int'(out_a), 0);
    chk("rst_mid_cnt", int'(cnt_a), 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_seq("rst_pulse", 16'b00101, 16'b00001, 5);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_kill_out", int'(out_a), 0);
    chk("rst_kill_cnt", int'(cnt_a), 0);

    // Randomised tail, checked by the model each cycle
    pat_in = 5'b01101; mask_in = 5'b01011;
    load(pat_in, mask_in);
    for (int i = 0; i < 400; i++) begin
      if (i % 23 == 0) overlap = 1'(($urandom >> 3) & 1);
      pat_in  = 5'($urandom);
      mask_in = 5'($urandom) & 5'($urandom);
      drive(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 9) < 8),
            1'($urandom), 1'($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 49) == 0));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/pattern_det_param.md
# pattern_det_param

Parametrised serial pattern detector, the successor to the fixed 5-bit `pattern_det`. It samples one bit per `clk` while `valid` is high and compares the last `PAT_LEN` accepted bits against a run-time-loadable pattern with a per-bit don't-care mask. On a match it pulses `out`, in either overlapping or non-overlapping mode, and keeps a saturating match count. It sits between the serial bit source and the stats/control logic that previously counted `out` edges in the bench.

## Interface

Parameters:
- `PAT_LEN`, 5: pattern length in bits, legal range 2–32.
- `PAT_RST`, 5'b00101: pattern loaded at reset. MSB is compared to the oldest bit. The default encodes B B C B C with B=0 and C=1.
- `CNT_W`, 16: width of `match_count`.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `valid`, in, 1: qualifies `in`. A bit is accepted only when `valid`=1.
- `in`, in, 1: serial data bit.
- `overlap`, in, 1: 1 selects overlapping detection; 0 selects non-overlapping.
- `pat_load`, in, 1: loads `pat_in` and `mask_in`.
- `pat_in`, in, PAT_LEN: new pattern, MSB = oldest bit.
- `mask_in`, in, PAT_LEN: 1 = compare this bit, 0 = don't care.
- `count_clr`, in, 1: clears `match_count`.
- `out`, out, 1: one-cycle registered match pulse.
- `match_count`, out, CNT_W: number of matches, saturating.

## Operation

- Internal state:
  - `hist[PAT_LEN-1:0]`: shift register of accepted bits; new bit enters at the LSB.
  - `fill`: count of accepted bits since the last clear, saturating at PAT_LEN.
  - `pat` and `mask` registers.
- Reset (`rst`=1 at the edge):
  - `hist`=0 and `fill`=0.
  - `pat`=PAT_RST and `mask`=all ones.
  - `out`=0 and `match_count`=0.
  - `rst` overrides every other input.
- Accepted bit (`valid`=1, `pat_load`=0):
  - Next history: `nh = {hist[PAT_LEN-2:0], in}`.
  - Next fill: `nf = min(fill+1, PAT_LEN)`.
  - Match condition: `nf`==PAT_LEN and `((nh ^ pat) & mask)`==0.
- On a match:
  - `out`=1 for the next cycle.
  - `match_count` increments, unless it is already all ones.
  - Overlap mode (`overlap`=1): `hist`=nh and `fill`=nf, so the next match can come 1 bit later.
  - Non-overlap mode (`overlap`=0): `fill`=0 and `hist` is don't-care; the next match needs PAT_LEN fresh bits.
- No match: `hist`=nh, `fill`=nf, `out`=0.
- `valid`=0: `hist` and `fill` hold, and `out`=0 on the next cycle. Gaps in `valid` do not break a partial pattern.
- `pat_load`=1:
  - `pat`=pat_in, `mask`=mask_in, `fill`=0.
  - Any `valid` bit in the same cycle is discarded and `out`=0.
  - `match_count` is unaffected.
- `mask` = all zeros: every accepted bit after the first PAT_LEN bits (fill full) is a match.
- `overlap` is sampled per accepted bit, so a change applies from the next accepted bit.
- `count_clr`: `match_count`=0 on the next cycle. It has priority over a simultaneous increment, and that match is lost from the count (`out` still pulses).

## Timing

- Latency is 1 cycle. The bit accepted at edge N produces `out`=1 during the cycle after edge N. `match_count` updates at the same edge.
- Maximum rate is 1 match per cycle (overlap mode with back-to-back matches); `out` then stays high for consecutive cycles.
- After reset or `pat_load`, the earliest match is on the PAT_LEN-th accepted bit.
- `rst` asserted mid-pattern discards the partial history. A pulse already on `out` is cleared at that edge.

## Test plan

- Default pattern 00101, overlap=1, `valid` continuous, stream 0,0,1,0,1 → `out` pulses once, 1 cycle after the 5th bit; `match_count`=1.
- `pat_load` with pat=10101 and mask=11111, stream 1,0,1,0,1,0,1:
  - overlap=1 → pulses after bits 5 and 7; `match_count`=2.
  - overlap=0 → pulse after bit 5 only; `match_count`=1.
- Default pattern, stream 0,0,1 then `valid`=0 for 3 cycles then 0,1 → exactly one pulse, after the final bit. `out`=0 throughout the gap.
- mask=11011 with pat=00101, streams 00101 and 00001 (each preceded by `pat_load` to clear `fill`) → both match; `match_count`=2.
- CNT_W=2, 5 back-to-back matches → `match_count` sequence 1,2,3,3,3. Then `count_clr` together with a match → `match_count`=0 and `out`=1.
- `rst` asserted after bits 0,0,1,0, then `in`=1 → no pulse; `out`=0 and `match_count`=0.
